// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, DIGIT bits per clock with the borrow registered between digits.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = $clog2(STEPS) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end
  logic [1:0] state;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_next;
  logic run_borrow;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] br;
  logic [DIGIT-1:0] dig;
  logic last;
  assign br[0] = run_borrow;
  for (genvar g = 0; g < DIGIT; g++) begin : g_fs
    assign dig[g] = a_sh[g] ^ b_sh[g] ^ br[g];
    assign br[g+1] = (~a_sh[g] & b_sh[g]) | (~(a_sh[g] ^ b_sh[g]) & br[g]);
  end
  // new digit enters at the top; after STEPS shifts the LSB digit has reached bit 0
  assign d_next = (d_sh >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
  assign last = cnt == CW'(STEPS - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      run_borrow <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sh <= a;
        b_sh <= b;
        run_borrow <= bin;
        cnt <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      d_sh <= d_next;
      run_borrow <= br[DIGIT];
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        diff <= d_next;
        borrow <= br[DIGIT];
        zero <= ~|d_next;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of three configurations (W1/D1, W8/D1, W8/D4) against an arithmetic scoreboard.
module tb_serial_subtractor;
  typedef struct packed {
    logic [7:0] d;
    logic bo;
    logic z;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0;
  int sel = 0;
  logic [7:0] a = '0, b = '0;
  logic bin = 1'b0;
  logic start1, start8, start4;
  logic busy1, busy8, busy4, done1, done8, done4;
  logic borrow1, borrow8, borrow4, zero1, zero8, zero4;
  logic [0:0] diff1;
  logic [7:0] diff8, diff4;
  logic busy_m, done_m, borrow_m, zero_m;
  logic [7:0] diff_m;
  logic [7:0] last_d [3];
  res_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign start1 = go && sel == 0;
  assign start8 = go && sel == 1;
  assign start4 = go && sel == 2;
  serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a[0:0]), .b(b[0:0]), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .zero(zero1)
  );
  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .bin(bin),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8)
  );
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .zero(zero4)
  );
  always_comb begin
    busy_m = sel == 0 ? busy1 : sel == 1 ? busy8 : busy4;
    done_m = sel == 0 ? done1 : sel == 1 ? done8 : done4;
    borrow_m = sel == 0 ? borrow1 : sel == 1 ? borrow8 : borrow4;
    zero_m = sel == 0 ? zero1 : sel == 1 ? zero8 : zero4;
    diff_m = sel == 0 ? {7'b0, diff1} : sel == 1 ? diff8 : diff4;
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic res_t model(input int s, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    logic [8:0] t;
    res_t r;
    t = s == 0 ? {8'b0, av[0]} - {8'b0, bv[0]} - {8'b0, bi} : {1'b0, av} - {1'b0, bv} - {8'b0, bi};
    r.d = s == 0 ? {7'b0, t[0]} : t[7:0];
    r.bo = t[8];
    r.z = r.d == 8'h00;
    return r;
  endfunction
  task automatic op(input int s, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                    input int steps, input bit hold = 0, input bit disturb = 0, input bit abort = 0);
    res_t e;
    int n;
    sel = s;
    @(negedge clk);
    a = av;
    b = bv;
    bin = bi;
    go = 1'b1;
    q.push_back(model(s, av, bv, bi));
    @(posedge clk);
    #1 go = 1'b0;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_m) break;
      if (busy_m) n++;
      if (hold && c == 1) chk("hold_in_run", diff_m, last_d[s]);
      if (disturb && c == 3) begin
        go = 1'b1;
        a = 8'hFF;
        b = 8'h00;
      end
      if (disturb && c == 4) begin
        go = 1'b0;
        a = 8'h77;
        b = 8'h11;
        bin = 1'b1;
      end
      if (abort && c == 4) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {7'b0, busy_m}, 8'h00);
        chk("abort_done", {7'b0, done_m}, 8'h00);
        chk("abort_diff", diff_m, 8'h00);
        chk("abort_borrow", {7'b0, borrow_m}, 8'h00);
        chk("abort_zero", {7'b0, zero_m}, 8'h00);
        void'(q.pop_back());
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("abort_no_done", {7'b0, done_m}, 8'h00);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) last_d[k] = 8'h00;
        return;
      end
    end
    chk("done_seen", {7'b0, done_m}, 8'h01);
    chk("busy_cycles", 8'(n), 8'(steps));
    e = q.pop_front();
    chk("diff", diff_m, e.d);
    chk("borrow", {7'b0, borrow_m}, {7'b0, e.bo});
    chk("zero", {7'b0, zero_m}, {7'b0, e.z});
    last_d[s] = e.d;
    @(negedge clk);
    chk("done_one_cycle", {7'b0, done_m}, 8'h00);
    chk("diff_held", diff_m, e.d);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) last_d[k] = 8'h00;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_busy", {7'b0, busy_m}, 8'h00);
      chk("rst_done", {7'b0, done_m}, 8'h00);
      chk("rst_diff", diff_m, 8'h00);
      chk("rst_borrow", {7'b0, borrow_m}, 8'h00);
      chk("rst_zero", {7'b0, zero_m}, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    op(0, 8'h00, 8'h00, 1'b0, 1);
    op(0, 8'h00, 8'h01, 1'b0, 1);
    op(0, 8'h01, 8'h00, 1'b0, 1);
    op(0, 8'h01, 8'h01, 1'b0, 1);
    op(1, 8'h05, 8'h03, 1'b0, 8);
    op(1, 8'h03, 8'h05, 1'b0, 8);
    op(1, 8'h00, 8'h00, 1'b1, 8);
    op(1, 8'h5A, 8'h5A, 1'b0, 8);
    op(2, 8'h12, 8'h01, 1'b0, 2);
    op(2, 8'hA5, 8'h5A, 1'b0, 2, 1);
    op(1, 8'h20, 8'h07, 1'b0, 8, 1, 1);
    op(1, 8'h44, 8'h22, 1'b0, 8, 0, 0, 1);
    op(1, 8'h10, 8'h01, 1'b0, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor that computes diff = a - b - bin over WIDTH bits.
- Processes DIGIT bits per clock through an internal ripple of full-subtractor cells, with the borrow registered between digits.
- It is the sequential, width-generalised successor of the half subtractor. It is used where a wide subtract must trade latency for area.
- Start/busy/done handshake; the result is held until the next operation completes.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥1.
- DIGIT, 1: bits processed per clock. Must be ≥1, and WIDTH must be a multiple of DIGIT; elaboration fails otherwise.
- STEPS (derived, not overridable), WIDTH/DIGIT: number of processing cycles.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured when start is accepted
- b  input  WIDTH  subtrahend, captured when start is accepted
- bin  input  1  borrow-in to the LSB, captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a result is committed
- diff  output  WIDTH  registered difference (a - b - bin) mod 2^WIDTH
- borrow  output  1  registered borrow-out of the MSB; 1 when a < b + bin, unsigned
- zero  output  1  registered; 1 when committed diff == 0

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, diff=0, borrow=0, zero=0; internal shift registers and counter cleared.
- A reset during RUN aborts the operation: no done pulse, and the prior result is lost (outputs are 0).
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge E0: capture a, b and bin into internal operand shift registers and the running-borrow register; cnt=0; go to RUN.
  - If start=0: stay in IDLE.
- RUN, one digit per edge:
  - Compute the low DIGIT bits of a_sh - b_sh - run_borrow as a chain of DIGIT full-subtractor cells: d_i = x ^ y ^ bi, bo = (~x & y) | (~(x ^ y) & bi).
  - Shift the result digit into the top of the diff shift register. Shift a_sh and b_sh right by DIGIT. run_borrow takes the chain's borrow-out. cnt increments.
  - After the edge that processes digit STEPS-1 (edge E_STEPS), go to DONE.
- Commit (same edge E_STEPS):
  - diff output takes the completed diff shift register.
  - borrow takes the final run_borrow.
  - zero is set from the completed diff.
  - done=1.
- DONE: lasts exactly one cycle. done falls at the next edge and the state returns to IDLE.
- Latency: done is high in the cycle after edge E_STEPS, i.e. STEPS cycles after the accepting edge. The next start can be accepted at E_STEPS+2 at the earliest.
- busy: 1 exactly in RUN, from after E0 through E_STEPS, which is STEPS cycles.
- start is ignored in RUN and DONE; operand inputs may change freely after E0.
- diff, borrow and zero hold their last committed values through IDLE and RUN and change only at a commit edge.
- Counter width: clog2(STEPS)+1 bits, with no wrap-around within an operation.
- Special cases:
  - DIGIT == WIDTH: STEPS=1, giving single-cycle processing.
  - WIDTH=1, bin=0: equals the half subtractor truth table.

Test Plan:
- WIDTH=1, DIGIT=1, bin=0; sweep (a,b) = 00, 01, 10, 11 -> (diff,borrow) = (0,0), (1,1), (1,0), (0,0); done 1 cycle after each accepting edge.
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> diff=0x02, borrow=0, zero=0. busy is high for 8 cycles, and done pulses once in the cycle after edge E8. Then a=0x03, b=0x05 -> diff=0xFE, borrow=1.
- WIDTH=8, DIGIT=1: a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1. Then a=0x5A, b=0x5A, bin=0 -> diff=0x00, borrow=0, zero=1.
- WIDTH=8, DIGIT=4: a=0xA5, b=0x5A, bin=0 -> diff=0x4B, borrow=0, done after 2 cycles. During RUN, diff still shows the previous result.
- WIDTH=8, DIGIT=1: pulse start again at E3 with a=0xFF, b=0x00 -> ignored; result is that of the first operation. Change a/b during RUN -> no effect on the result.
- WIDTH=8, DIGIT=1: assert rst asynchronously (mid-cycle) at cycle 4 of RUN -> all outputs are 0 immediately and no done pulse occurs. After release, a new start with a=0x10, b=0x01 -> diff=0x0F, borrow=0.
